// File: rtl/rc4_decrypt_engine.sv
// RC4 decrypt engine: fills S, runs the key schedule, then XORs keystream over MSG_LEN bytes.
// Every memory-facing output is registered; the S RAM is single-port with a 2-cycle read.

module rc4_decrypt_engine #(
    parameter int unsigned  ADDR_W    = 8,
    parameter int unsigned  KEY_BYTES = 3,
    parameter int unsigned  MSG_LEN   = 32,
    parameter bit           CHECK_EN  = 1'b1,
    localparam int unsigned MSG_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
    localparam int unsigned KEY_W     = 8 * KEY_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KEY_W-1:0]  key,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] s_addr,
    output logic [ADDR_W-1:0] s_wdata,
    output logic              s_wren,
    input  logic [ADDR_W-1:0] s_rdata,
    output logic [MSG_W-1:0]  e_addr,
    input  logic [7:0]        e_rdata,
    output logic [MSG_W-1:0]  d_addr,
    output logic [7:0]        d_wdata,
    output logic              d_wren
);

    localparam int unsigned KI_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [4:0] {
        StIdle, StInit,
        StKRdI, StKWtI, StKLdI, StKWtJ, StKLdJ, StKWrJ,
        StPRdI, StPWtI, StPLdI, StPWtJ, StPLdJ, StPWrJ, StPRdF, StPWtF, StPLdF,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [MSG_W-1:0]  k_q, k_d;
    logic [KI_W-1:0]   kidx_q, kidx_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [7:0]        e_q, e_d;
    logic              res_q, res_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
    logic              s_wren_q, s_wren_d, d_wren_q, d_wren_d;
    logic [MSG_W-1:0]  e_addr_q, e_addr_d, d_addr_q, d_addr_d;
    logic [7:0]        d_wdata_q, d_wdata_d;

    logic [ADDR_W-1:0] kb, i_inc, j_ksa, j_prga, f_addr;
    logic [7:0]        plain;
    logic              plain_ok, i_last, k_last, kidx_last;

    // Key byte (i mod KEY_BYTES), truncated to the low ADDR_W bits.
    always_comb begin
        kb = '0;
        for (int n = 0; n < int'(KEY_BYTES); n++) begin
            if (kidx_q == KI_W'(n)) kb = key_q[KEY_W - 8 - 8 * n +: ADDR_W];
        end
    end

    assign i_inc     = i_q + 1'b1;
    assign j_ksa     = j_q + s_rdata + kb;
    assign j_prga    = j_q + s_rdata;
    assign f_addr    = si_q + sj_q;
    assign plain     = e_q ^ 8'(s_rdata);
    assign plain_ok  = (plain == 8'h20) || (plain >= 8'h61 && plain <= 8'h7A);
    assign i_last    = (i_q == {ADDR_W{1'b1}});
    assign k_last    = (k_q == MSG_W'(MSG_LEN - 1));
    assign kidx_last = (kidx_q == KI_W'(KEY_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            i_q       <= '0;
            j_q       <= '0;
            si_q      <= '0;
            sj_q      <= '0;
            k_q       <= '0;
            kidx_q    <= '0;
            key_q     <= '0;
            e_q       <= '0;
            res_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wren_q  <= 1'b0;
            e_addr_q  <= '0;
            d_addr_q  <= '0;
            d_wdata_q <= '0;
            d_wren_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            k_q       <= k_d;
            kidx_q    <= kidx_d;
            key_q     <= key_d;
            e_q       <= e_d;
            res_q     <= res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_wren_q  <= s_wren_d;
            e_addr_q  <= e_addr_d;
            d_addr_q  <= d_addr_d;
            d_wdata_q <= d_wdata_d;
            d_wren_q  <= d_wren_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        sj_d      = sj_q;
        k_d       = k_q;
        kidx_d    = kidx_q;
        key_d     = key_q;
        e_d       = e_q;
        res_d     = res_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_wren_d  = 1'b0;
        e_addr_d  = e_addr_q;
        d_addr_d  = d_addr_q;
        d_wdata_d = d_wdata_q;
        d_wren_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StInit;
                    i_d     = '0;
                    key_d   = key;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                end
            end
            StInit: begin
                s_addr_d  = i_q;
                s_wdata_d = i_q;
                s_wren_d  = 1'b1;
                i_d       = i_inc;
                if (i_last) begin
                    state_d = StKRdI;
                    j_d     = '0;
                    kidx_d  = '0;
                end
            end
            StKRdI: begin
                s_addr_d = i_q;
                state_d  = StKWtI;
            end
            StKWtI: state_d = StKLdI;
            StKLdI: begin
                si_d     = s_rdata;
                j_d      = j_ksa;
                s_addr_d = j_ksa;
                state_d  = StKWtJ;
            end
            StKWtJ: state_d = StKLdJ;
            StKLdJ: begin
                sj_d      = s_rdata;
                s_addr_d  = i_q;
                s_wdata_d = s_rdata;
                s_wren_d  = 1'b1;
                state_d   = StKWrJ;
            end
            StKWrJ: begin
                s_addr_d  = j_q;
                s_wdata_d = si_q;
                s_wren_d  = 1'b1;
                if (i_last) begin
                    state_d = StPRdI;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end else begin
                    state_d = StKRdI;
                    i_d     = i_inc;
                    kidx_d  = kidx_last ? '0 : kidx_q + 1'b1;
                end
            end
            StPRdI: begin
                i_d      = i_inc;
                s_addr_d = i_inc;
                e_addr_d = k_q;
                state_d  = StPWtI;
            end
            StPWtI: state_d = StPLdI;
            StPLdI: begin
                si_d     = s_rdata;
                j_d      = j_prga;
                s_addr_d = j_prga;
                state_d  = StPWtJ;
            end
            StPWtJ: state_d = StPLdJ;
            StPLdJ: begin
                sj_d      = s_rdata;
                s_addr_d  = i_q;
                s_wdata_d = s_rdata;
                s_wren_d  = 1'b1;
                e_d       = e_rdata;
                state_d   = StPWrJ;
            end
            StPWrJ: begin
                s_addr_d  = j_q;
                s_wdata_d = si_q;
                s_wren_d  = 1'b1;
                state_d   = StPRdF;
            end
            StPRdF: begin
                s_addr_d = f_addr;
                state_d  = StPWtF;
            end
            StPWtF: state_d = StPLdF;
            StPLdF: begin
                d_addr_d  = k_q;
                d_wdata_d = plain;
                d_wren_d  = 1'b1;
                // A failing byte is still written before the run aborts.
                if (CHECK_EN && !plain_ok) begin
                    res_d   = 1'b0;
                    state_d = StDone;
                end else if (k_last) begin
                    res_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = StPRdI;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = res_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_wren  = s_wren_q;
    assign e_addr  = e_addr_q;
    assign d_addr  = d_addr_q;
    assign d_wdata = d_wdata_q;
    assign d_wren  = d_wren_q;

endmodule
